// File: rtl/logic_func_unit_pkg.sv
// Shared constants for the logic function unit: truth-table op codes,
// sweep bounds, FSM state encoding and the per-bit evaluation rule.
package logic_func_unit_pkg;

  localparam logic [3:0] OP_AND     = 4'h8;
  localparam logic [3:0] OP_OR      = 4'hE;
  localparam logic [3:0] OP_XOR     = 4'h6;
  localparam logic [3:0] OP_NOR     = 4'h1;
  localparam logic [3:0] OP_NAND    = 4'h7;
  localparam logic [3:0] OP_INHIBIT = 4'h4;

  localparam logic [1:0] SWEEP_LAST = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // op is a truth table indexed by the {a,b} input combination
  function automatic logic eval_bit(input logic [3:0] op, input logic a, input logic b);
    return op[{a, b}];
  endfunction

endpackage

// File: rtl/logic_func_unit_bit.sv
// One bit slice of the logic function unit: selects the truth-table entry
// addressed by the operand bit pair.
module logic_func_bit
  import logic_func_unit_pkg::*;
(
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  output logic       s
);

  assign s = eval_bit(op, a, b);

endmodule

// File: rtl/logic_func_unit.sv
// Two-input bitwise function unit with a one-entry registered output stage
// and a truth-table sweep mode that emits op[0..3] as replicated results.
//
//   state | meaning
//   IDLE  | normal operand requests accepted, output holds last result
//   SWEEP | emitting op_q[idx] for idx 0..3, one per transfer-out
module logic_func_unit
  import logic_func_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic [WIDTH-1:0] s,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] f;
  logic             slot_free;
  logic             transfer;
  logic             accept;
  logic             start;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic_func_bit u_bit (
      .op (op),
      .a  (a[i]),
      .b  (b[i]),
      .s  (f[i])
    );
  end

  assign slot_free  = !out_valid || out_ready;
  assign transfer   = out_valid && out_ready;
  assign in_ready   = (state == IDLE) && !sweep_start && slot_free;
  assign accept     = in_valid && in_ready;
  assign start      = (state == IDLE) && sweep_start && slot_free;
  assign idx_next   = idx + 2'd1;
  assign sweep_busy = (state == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_q      <= '0;
      s         <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // first sweep result comes straight from op; op_q takes over after
            state     <= SWEEP;
            op_q      <= op;
            idx       <= '0;
            s         <= {WIDTH{op[0]}};
            out_idx   <= '0;
            out_valid <= 1'b1;
          end else if (accept) begin
            s         <= f;
            out_idx   <= '0;
            out_valid <= 1'b1;
          end else if (transfer) begin
            out_valid <= 1'b0;
          end
        end
        SWEEP: begin
          if (transfer) begin
            if (idx == SWEEP_LAST) begin
              state     <= IDLE;
              idx       <= '0;
              out_idx   <= '0;
              out_valid <= 1'b0;
            end else begin
              idx     <= idx_next;
              s       <= {WIDTH{op_q[idx_next]}};
              out_idx <= idx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_func_unit.sv
// Scoreboard bench for logic_func_unit: driver predicts results from a
// minterm-sum model into a queue, a negedge monitor pops and compares.
module tb_logic_func_unit;

  localparam int WIDTH = 8;

  typedef struct {
    logic [1:0]       idx;
    logic [WIDTH-1:0] val;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic             sweep_start;
  logic             sweep_busy;
  logic [WIDTH-1:0] s;
  logic [1:0]       out_idx;
  logic             out_valid;
  logic             out_ready;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  bit   m_valid  = 0;
  int   m_left   = 0;

  logic_func_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .s           (s),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // sum of selected minterms: op[3]:a&b, op[2]:a&~b, op[1]:~a&b, op[0]:~a&~b
  function automatic logic [WIDTH-1:0] ref_f(input logic [3:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    if (o[3]) r = r | (x & y);
    if (o[2]) r = r | (x & ~y);
    if (o[1]) r = r | (~x & y);
    if (o[0]) r = r | (~x & ~y);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual s=%0h idx=%0d required none", s, out_idx);
      end else begin
        chk("result_s", s, exp_q[0].val);
        chk("result_idx", out_idx, exp_q[0].idx);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic ss, input logic orr, input logic [3:0] o,
                      input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
    bit   xfer, start, acc, exp_rdy;
    exp_t e;
    in_valid    = iv;
    sweep_start = ss;
    out_ready   = orr;
    op          = o;
    a           = aa;
    b           = bb;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("sweep_busy", sweep_busy, m_left != 0);
    xfer    = m_valid && orr;
    exp_rdy = (m_left == 0) && !ss && (!m_valid || orr);
    chk("in_ready", in_ready, exp_rdy);
    start = (m_left == 0) && ss && (!m_valid || orr);
    acc   = iv && exp_rdy;
    if (start) begin
      for (int k = 0; k < 4; k++) begin
        e.idx = k[1:0];
        e.val = o[k] ? {WIDTH{1'b1}} : '0;
        exp_q.push_back(e);
      end
      m_left  = 4;
      m_valid = 1;
    end else if (acc) begin
      e.idx = 2'd0;
      e.val = ref_f(o, aa, bb);
      exp_q.push_back(e);
      m_valid = 1;
    end else if (xfer) begin
      if (m_left > 0) begin
        m_left--;
        m_valid = (m_left != 0);
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 4'h0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; in_valid = 0; sweep_start = 0; out_ready = 0;
    op = '0; a = '0; b = '0;
    #1;
    chk("rst_s", s, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_sweep_busy", sweep_busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // single INHIBIT op, latency one cycle
    step(1, 0, 1, 4'h4, 8'hF0, 8'hCC);
    chk("inhibit_s", s, 8'h30);
    chk("inhibit_valid", out_valid, 1);
    chk("inhibit_idx", out_idx, 0);
    idle(1);

    // back-to-back truth-table walk of INHIBIT
    step(1, 0, 1, 4'h4, 8'h01, 8'h00);
    step(1, 0, 1, 4'h4, 8'h00, 8'h00);
    step(1, 0, 1, 4'h4, 8'h01, 8'h01);
    step(1, 0, 1, 4'h4, 8'h00, 8'h01);
    idle(2);

    // stalled output holds while inputs move
    step(1, 0, 0, 4'h8, 8'hA5, 8'h3C);
    step(1, 0, 0, 4'hE, 8'h11, 8'h22);
    step(1, 0, 0, 4'h6, 8'h33, 8'h44);
    step(1, 0, 0, 4'h1, 8'h55, 8'h66);
    chk("stall_s", s, 8'h24);
    step(0, 0, 1, 4'h0, 8'h00, 8'h00);
    idle(2);

    // XOR sweep with op disturbed mid-sweep
    step(0, 1, 1, 4'h6, 8'h00, 8'h00);
    chk("sweep_busy_on", sweep_busy, 1);
    step(0, 0, 1, 4'h9, 8'h00, 8'h00);
    step(0, 1, 1, 4'hF, 8'h00, 8'h00);
    step(0, 0, 1, 4'h0, 8'h00, 8'h00);
    step(0, 0, 1, 4'h0, 8'h00, 8'h00);
    chk("sweep_done_busy", sweep_busy, 0);
    idle(1);

    // sweep_start beats in_valid; request held until idle
    step(1, 1, 1, 4'hE, 8'h0F, 8'hF0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 4'h8, 8'hFF, 8'h0F);
    idle(2);

    // reset after the second sweep result appears
    step(0, 1, 1, 4'h7, 8'h00, 8'h00);
    step(0, 0, 1, 4'h7, 8'h00, 8'h00);
    rst_n = 0;
    #1;
    chk("midrst_s", s, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_idx", out_idx, 0);
    chk("midrst_busy", sweep_busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    m_valid = 0;
    m_left  = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle(4);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
           4'($urandom), 8'($urandom), 8'($urandom));

    idle(8);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_func_unit.md
LOGIC_FUNC_UNIT -- requirements
Module: logic_func_unit

Interface
REQ-001 Parameter WIDTH SHALL be declared: default 8; operand/result bit width, legal range 1..32.
REQ-002 Port clk SHALL be: input, 1 bit, single clock, all state on rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, reset, asynchronous and active-low.
REQ-004 Port op SHALL be: input, 4 bits, truth-table code selecting the two-input function.
REQ-005 Port a SHALL be: input, WIDTH bits, operand A.
REQ-006 Port b SHALL be: input, WIDTH bits, operand B.
REQ-007 Port in_valid SHALL be: input, 1 bit, operand request present.
REQ-008 Port in_ready SHALL be: output, 1 bit, unit accepts request this cycle.
REQ-009 Port sweep_start SHALL be: input, 1 bit, request truth-table sweep of op.
REQ-010 Port sweep_busy SHALL be: output, 1 bit, sweep in progress.
REQ-011 Port s SHALL be: output, WIDTH bits, registered result.
REQ-012 Port out_idx SHALL be: output, 2 bits, sweep combination {a,b} for current result; 0 in normal mode.
REQ-013 Port out_valid SHALL be: output, 1 bit, result held in s/out_idx.
REQ-014 Port out_ready SHALL be: input, 1 bit, consumer takes result.

Function
REQ-015 Bit i of any result SHALL equal op[{a[i],b[i]}]: 4'h8 AND, 4'hE OR, 4'h6 XOR, 4'h1 NOR, 4'h4 a&~b.
REQ-016 Output stage SHALL be a single registered entry; s, out_idx and out_valid change only on clk edges.
REQ-017 Transfer-out SHALL occur when out_valid && out_ready; s SHALL hold stable while out_valid && !out_ready.
REQ-018 in_ready SHALL be (state==IDLE) && !sweep_start && (!out_valid || out_ready).
REQ-019 Accept (in_valid && in_ready) SHALL load s=f(op,a,b), out_idx=0, out_valid=1 on the same edge; latency 1 cycle.
REQ-020 With no accept and a transfer-out, out_valid SHALL clear on that edge.
REQ-021 Back-to-back accepts SHALL sustain one result per cycle while out_ready=1.
REQ-022 FSM SHALL have states IDLE and SWEEP.
REQ-023 IDLE->SWEEP: sweep_start && (!out_valid || out_ready); op SHALL be latched into op_q and idx=0 on that edge, with first result loaded on that edge.
REQ-024 sweep_start in SWEEP, or while output is blocked, SHALL be ignored and not remembered.
REQ-025 sweep_start SHALL win over in_valid in the same cycle; the request is not accepted (in_ready=0).
REQ-026 In SWEEP each result SHALL be s={WIDTH{op_q[idx]}}, out_idx=idx; idx increments on each transfer-out.
REQ-027 Transfer-out with idx==3 SHALL return FSM to IDLE, clear out_valid, and reset idx to 0 (idx wraps to 0, never 4).
REQ-028 Changes to op during SWEEP SHALL not affect sweep results.
REQ-029 sweep_busy SHALL equal (state==SWEEP).

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, idx 0, op_q 0, s 0, out_idx 0, out_valid 0, sweep_busy 0.
REQ-031 Reset mid-sweep SHALL discard the sweep and pending result; no result emitted after release until a new accept/start.
REQ-032 in_ready SHALL be 1 during and after reset when sweep_start=0.

Structure
REQ-033 Shared package SHALL hold op constants (OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_INHIBIT=4'h4) and FSM state encoding.
REQ-034 Per-bit evaluation SHALL be a sub-module logic_func_bit (inputs op, a, b; output s), instantiated WIDTH times via generate.
REQ-035 RTL SHALL contain no latches and no combinational path from out_ready to s.

Verification
REQ-036 WIDTH=8, op=4'h4, a=8'hF0, b=8'hCC, out_ready=1 -> next cycle s=8'h30, out_valid=1, out_idx=0.
REQ-037 op=4'h4, a=8'h01, 8'h00, 8'h01, 8'h00, b=8'h00, 8'h00, 8'h01, 8'h01 back-to-back, out_ready=1 -> s=8'h01, 8'h00, 8'h00, 8'h00 on consecutive cycles.
REQ-038 out_ready=0 for 3 cycles after accept, op/a/b changing -> s stable, in_ready=0; out_ready=1 -> single transfer.
REQ-039 sweep_start with op=4'h6, out_ready=1 -> sweep_busy=1; (out_idx,s)=(0,00),(1,FF),(2,FF),(3,00) on 4 consecutive cycles; then IDLE.
REQ-040 sweep_start and in_valid same cycle -> sweep runs; request not accepted; in_ready=0 until IDLE.
REQ-041 rst_n low after second sweep result -> all outputs 0 asynchronously; after release, out_valid stays 0 with idle inputs.
